// File: rtl/core_pkg.sv
// Shared encodings for the RV32I multi-cycle sequencer: FSM states,
// PC source select codes and trap cause codes.
package core_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'b000,
        ST_FETCH  = 3'b001,
        ST_DECODE = 3'b010,
        ST_EXEC   = 3'b011,
        ST_MEM    = 3'b100,
        ST_WB     = 3'b101,
        ST_TRAP   = 3'b110
    } state_e;

    localparam logic [1:0] PC_SRC_SEQ = 2'b00;
    localparam logic [1:0] PC_SRC_IMM = 2'b01;
    localparam logic [1:0] PC_SRC_ALU = 2'b10;

    localparam logic [1:0] CAUSE_NONE        = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL     = 2'b01;
    localparam logic [1:0] CAUSE_MEM_TIMEOUT = 2'b10;

    // JALR target comes from the ALU; JAL and taken branches use PC+imm.
    function automatic logic [1:0] pc_select(input logic jump, input logic jalr,
                                             input logic branch, input logic taken);
        if (jump && jalr) return PC_SRC_ALU;
        if (jump || (branch && taken)) return PC_SRC_IMM;
        return PC_SRC_SEQ;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-state timer for the shared memory port: counts stalled cycles and
// flags the cycle in which the stall count reaches MEM_TIMEOUT.
module mem_wait_timer
    import core_pkg::*;
#(
    parameter int TMR_W       = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic count_i,
    output logic expired_o
);

    localparam logic [TMR_W:0] LIMIT = (TMR_W + 1)'(MEM_TIMEOUT);

    logic [TMR_W-1:0] cnt_q, cnt_d;
    logic [TMR_W:0]   cnt_inc;

    assign cnt_inc = {1'b0, cnt_q} + (TMR_W + 1)'(1);

    // Expires in the stalled cycle that would bring the count to the limit,
    // so a ready arriving in that same cycle still wins.
    assign expired_o = (MEM_TIMEOUT != 0) && count_i && (cnt_inc == LIMIT);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (count_i) begin
            cnt_d = cnt_q + TMR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle RV32I sequencer: walks each instruction through fetch, decode,
// execute, memory and writeback over one shared memory port.
//
// state  | meaning
// IDLE   | halted, waiting for en
// FETCH  | instruction read at PC, IR loads on mem_ready
// DECODE | illegal opcode check
// EXEC   | ALU cycle, chooses MEM or WB
// MEM    | data read/write at ALU result, MDR loads on ready for loads
// WB     | register/PC update, instruction retires
// TRAP   | sticky fault, only reset leaves
module core_sequencer
    import core_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 15,
    parameter int TMR_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             MemRead,
    input  logic             MemWrite,
    input  logic             RegWrite,
    input  logic             Branch,
    input  logic             Jump,
    input  logic             is_jalr,
    input  logic             illegal,
    input  logic             branch_taken,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic             ir_we,
    output logic             mdr_we,
    output logic             reg_we,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic [2:0]       state_o,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] retired
);

    state_e           state_q, state_d;
    logic [1:0]       cause_q, cause_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             waiting;
    logic             tmr_clear;
    logic             tmr_expired;

    assign waiting   = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !mem_ready;
    assign tmr_clear = mem_ready || (state_d != state_q);

    mem_wait_timer #(
        .TMR_W       (TMR_W),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (tmr_clear),
        .count_i   (waiting),
        .expired_o (tmr_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cause_q   <= CAUSE_NONE;
            retired_q <= '0;
        end else begin
            cause_q   <= cause_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        retired_d = retired_q;
        case (state_q)
            ST_IDLE: begin
                if (en) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (mem_ready) begin
                    state_d = ST_DECODE;
                end else if (tmr_expired) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_MEM_TIMEOUT;
                end
            end
            ST_DECODE: begin
                if (illegal) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = (MemRead || MemWrite) ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                if (mem_ready) begin
                    state_d = ST_WB;
                end else if (tmr_expired) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_MEM_TIMEOUT;
                end
            end
            ST_WB: begin
                retired_d = retired_q + CNT_W'(1);
                state_d   = en ? ST_FETCH : ST_IDLE;
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        mdr_we       = 1'b0;
        reg_we       = 1'b0;
        pc_we        = 1'b0;
        pc_src       = PC_SRC_SEQ;
        case (state_q)
            ST_FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ready;
            end
            ST_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = MemWrite;
                mdr_we       = MemRead && mem_ready;
            end
            ST_WB: begin
                reg_we = RegWrite;
                pc_we  = 1'b1;
                pc_src = pc_select(Jump, is_jalr, Branch, branch_taken);
            end
            default: ;
        endcase
    end

    assign state_o    = state_q;
    assign trap       = (state_q == ST_TRAP);
    assign trap_cause = cause_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Randomized scoreboard bench for core_sequencer: the driver pushes the
// expected outcome of each instruction, a negedge monitor pops and compares.
module tb_core_sequencer;

    localparam int CNT_W       = 32;
    localparam int MEM_TIMEOUT = 15;
    localparam int TMR_W       = 4;

    localparam int C_ALU = 0, C_LOAD = 1, C_STORE = 2, C_BRANCH = 3, C_JAL = 4, C_JALR = 5, C_ILL = 6;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en, MemRead, MemWrite, RegWrite, Branch, Jump, is_jalr, illegal;
    logic             branch_taken, mem_ready;
    logic             mem_req, mem_we, mem_addr_sel, ir_we, mdr_we, reg_we, pc_we;
    logic [1:0]       pc_src;
    logic [2:0]       state_o;
    logic             trap;
    logic [1:0]       trap_cause;
    logic [CNT_W-1:0] retired;

    always #5 clk = ~clk;

    core_sequencer #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT), .TMR_W(TMR_W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .MemRead(MemRead), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .Branch(Branch), .Jump(Jump), .is_jalr(is_jalr),
        .illegal(illegal), .branch_taken(branch_taken), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_we(ir_we),
        .mdr_we(mdr_we), .reg_we(reg_we), .pc_we(pc_we), .pc_src(pc_src),
        .state_o(state_o), .trap(trap), .trap_cause(trap_cause), .retired(retired)
    );

    typedef struct {
        bit is_trap;
        int cause;
        int lat;
        int freq;
        int dreq;
        int dwe;
        int ir;
        int mdr;
        int reg_we;
        int pc_src;
        longint ret_before;
    } exp_t;

    exp_t   exp_q[$];
    int     errors = 0;
    int     checks = 0;
    longint ret_model = 0;

    function automatic void chk(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endfunction

    // ---------------- monitor ----------------
    bit   in_instr = 0;
    bit   trap_seen = 0;
    int   held_cause = 3;
    int   cyc, freq, dreq, dwe, irc, mdrc, regc, ovl, badwe;
    exp_t e_mon;

    function automatic void clear_tallies();
        cyc = 0; freq = 0; dreq = 0; dwe = 0; irc = 0; mdrc = 0; regc = 0; ovl = 0; badwe = 0;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            in_instr  = 0;
            trap_seen = 0;
            clear_tallies();
            exp_q.delete();
        end else if (trap) begin
            if (!trap_seen) begin
                trap_seen = 1;
                chk("trap_pending", exp_q.size() > 0, 1);
                held_cause = 3;
                if (exp_q.size() > 0) begin
                    e_mon = exp_q.pop_front();
                    held_cause = e_mon.cause;
                    chk("trap_expected", trap, e_mon.is_trap);
                    chk("trap_cause", trap_cause, e_mon.cause);
                    chk("trap_fetch_cycles", freq, e_mon.freq);
                    chk("trap_data_cycles", dreq, e_mon.dreq);
                    chk("trap_store_cycles", dwe, e_mon.dwe);
                    chk("trap_ir_we", irc, e_mon.ir);
                    chk("trap_mdr_we", mdrc, 0);
                    chk("trap_reg_we", regc, 0);
                end
                in_instr = 0;
            end
            chk("trap_quiet", {mem_req, mem_we, mem_addr_sel, ir_we, mdr_we, reg_we, pc_we, pc_src}, 0);
            chk("trap_state", state_o, 6);
            chk("trap_hold", trap_cause, held_cause);
        end else begin
            if (mem_req && !in_instr) begin
                in_instr = 1;
                clear_tallies();
            end
            if (in_instr) begin
                cyc++;
                if (mem_req && !mem_addr_sel) freq++;
                if (mem_req && mem_addr_sel) dreq++;
                if (mem_req && mem_addr_sel && mem_we) dwe++;
                if (mem_we && !(mem_req && mem_addr_sel)) badwe++;
                if (ir_we) irc++;
                if (mdr_we) mdrc++;
                if (int'(ir_we) + int'(mdr_we) + int'(reg_we) > 1) ovl++;
                if (pc_we) begin
                    chk("wb_pending", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e_mon = exp_q.pop_front();
                        chk("wb_expected", trap, e_mon.is_trap);
                        chk("latency", cyc, e_mon.lat);
                        chk("fetch_cycles", freq, e_mon.freq);
                        chk("data_cycles", dreq, e_mon.dreq);
                        chk("store_cycles", dwe, e_mon.dwe);
                        chk("ir_we_count", irc, e_mon.ir);
                        chk("mdr_we_count", mdrc, e_mon.mdr);
                        chk("reg_we_early", regc, 0);
                        chk("reg_we", reg_we, e_mon.reg_we);
                        chk("pc_src", pc_src, e_mon.pc_src);
                        chk("retired", retired, e_mon.ret_before);
                        chk("we_overlap", ovl, 0);
                        chk("stray_mem_we", badwe, 0);
                    end
                    in_instr = 0;
                end else if (reg_we) begin
                    regc++;
                end
            end else begin
                chk("idle_quiet", {mem_req, mem_we, mem_addr_sel, ir_we, mdr_we, reg_we, pc_we, pc_src}, 0);
                chk("idle_state", state_o, 0);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic set_class(input int cls, input bit taken);
        MemRead = 0; MemWrite = 0; RegWrite = 0; Branch = 0; Jump = 0; is_jalr = 0; illegal = 0;
        branch_taken = taken;
        case (cls)
            C_ALU:    RegWrite = 1;
            C_LOAD:   begin MemRead = 1; RegWrite = 1; end
            C_STORE:  MemWrite = 1;
            C_BRANCH: Branch = 1;
            C_JAL:    begin Jump = 1; RegWrite = 1; end
            C_JALR:   begin Jump = 1; is_jalr = 1; RegWrite = 1; end
            default:  begin
                illegal  = 1;
                RegWrite = 1'($urandom_range(0, 1));
                MemRead  = 1'($urandom_range(0, 1));
            end
        endcase
    endtask

    task automatic do_reset();
        rst_n = 0;
        en = 0;
        mem_ready = 0;
        #1;
        chk("rst_quiet", {mem_req, mem_we, mem_addr_sel, ir_we, mdr_we, reg_we, pc_we, pc_src}, 0);
        chk("rst_state", state_o, 0);
        chk("rst_trap", {trap, trap_cause}, 0);
        chk("rst_retired", retired, 0);
        ret_model = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic do_instr(input int cls, input int fw, input int mw, input bit taken, input bit en_next);
        exp_t e;
        bit   is_mem;
        bit   wb;
        bit   done;
        int   fc, mc;
        is_mem = (cls == C_LOAD) || (cls == C_STORE);
        fc = 0; mc = 0; done = 0;
        set_class(cls, taken);
        e = '{default: 0};
        e.ret_before = ret_model;
        if (fw >= MEM_TIMEOUT) begin
            e.is_trap = 1; e.cause = 2; e.freq = MEM_TIMEOUT;
        end else begin
            e.freq = fw + 1;
            e.ir   = 1;
            if (cls == C_ILL) begin
                e.is_trap = 1; e.cause = 1;
            end else if (is_mem && mw >= MEM_TIMEOUT) begin
                e.is_trap = 1; e.cause = 2; e.dreq = MEM_TIMEOUT;
                e.dwe = (cls == C_STORE) ? MEM_TIMEOUT : 0;
            end else begin
                e.dreq   = is_mem ? mw + 1 : 0;
                e.dwe    = (cls == C_STORE) ? mw + 1 : 0;
                e.mdr    = (cls == C_LOAD) ? 1 : 0;
                e.reg_we = (cls == C_ALU || cls == C_LOAD || cls == C_JAL || cls == C_JALR) ? 1 : 0;
                e.pc_src = (cls == C_JALR) ? 2 : ((cls == C_JAL || (cls == C_BRANCH && taken)) ? 1 : 0);
                e.lat    = e.freq + 2 + e.dreq + 1;
                ret_model++;
            end
        end
        exp_q.push_back(e);
        en = 1;
        for (int n = 0; n < 200 && !done; n++) begin
            if (trap) begin
                done = 1;
            end else begin
                if (mem_req && !mem_addr_sel) begin
                    if (fc < fw) begin mem_ready = 0; fc++; end
                    else begin mem_ready = 1; en = en_next; end
                end else if (mem_req) begin
                    if (mc < mw) begin mem_ready = 0; mc++; end
                    else mem_ready = 1;
                end else begin
                    mem_ready = 1'($urandom_range(0, 1));
                end
                wb = pc_we;
                @(posedge clk);
                #1;
                if (wb) done = 1;
            end
        end
        mem_ready = 0;
        chk("instr_budget", done, 1);
        if (trap) begin
            repeat (3) begin
                en = 1'($urandom_range(0, 1));
                mem_ready = 1'($urandom_range(0, 1));
                @(posedge clk);
                #1;
            end
            do_reset();
        end
    endtask

    task automatic reset_mid_mem();
        bit hit;
        int mc;
        hit = 0; mc = 0;
        set_class(C_LOAD, 0);
        en = 1;
        for (int n = 0; n < 60 && !hit; n++) begin
            if (mem_req && mem_addr_sel) begin
                if (mc == 3) hit = 1;
                else begin mc++; mem_ready = 0; end
            end else if (mem_req) begin
                mem_ready = 1;
                en = 0;
            end else begin
                mem_ready = 0;
            end
            if (!hit) begin
                @(posedge clk);
                #1;
            end
        end
        chk("pre_reset_mem_req", mem_req, 1);
        do_reset();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cls, fw, mw, r;
        rst_n = 0; en = 0; mem_ready = 0;
        set_class(C_ALU, 0);
        #12;
        chk("por_quiet", {mem_req, mem_we, mem_addr_sel, ir_we, mdr_we, reg_we, pc_we, pc_src}, 0);
        chk("por_state", state_o, 0);
        chk("por_trap", {trap, trap_cause}, 0);
        chk("por_retired", retired, 0);
        @(posedge clk);
        #1 rst_n = 1;

        do_instr(C_ALU,    0,  0, 0, 1);
        do_instr(C_LOAD,   0,  2, 0, 1);
        do_instr(C_STORE,  0,  0, 0, 1);
        do_instr(C_BRANCH, 1,  0, 1, 1);
        do_instr(C_BRANCH, 0,  0, 0, 1);
        do_instr(C_JAL,    2,  0, 0, 1);
        do_instr(C_JALR,   0,  0, 0, 0);
        do_instr(C_ALU,    14, 0, 0, 0);
        do_instr(C_STORE,  0, 14, 0, 0);
        reset_mid_mem();
        do_instr(C_ALU,    0,  0, 0, 0);
        do_instr(C_ILL,    0,  0, 0, 1);
        do_instr(C_ALU,    99, 0, 0, 1);
        do_instr(C_LOAD,   0, 99, 0, 1);

        for (int i = 0; i < 120; i++) begin
            r   = $urandom_range(0, 19);
            cls = (r < 18) ? (r % 6) : C_ILL;
            r   = $urandom_range(0, 29);
            fw  = (r < 24) ? (r % 4) : ((r < 27) ? 14 : 99);
            r   = $urandom_range(0, 29);
            mw  = (r < 24) ? (r % 4) : ((r < 27) ? 14 : 99);
            do_instr(cls, fw, mw, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
        end

        do_instr(C_ALU, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("final_retired", retired, ret_model);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
- Multi-cycle sequencer for the RV32I core.
- Steps each instruction through fetch, decode, execute, memory and writeback.
- Consumes the decoded control signals (ALUSrc/MemRead/MemWrite/RegWrite/Branch/Jump class) plus a JALR flag and an illegal flag.
- Drives register/PC/IR write enables and a single shared memory port with a req/ready handshake. Also keeps a retired-instruction counter and a sticky trap.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.
- MEM_TIMEOUT, 15, maximum cycles waiting for mem_ready before trapping; 0 disables the timeout.
- TMR_W, 4, width of the wait timer; must satisfy MEM_TIMEOUT < 2**TMR_W.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  run enable; sampled only in IDLE and WB.
- MemRead  in  1  decoded load.
- MemWrite  in  1  decoded store.
- RegWrite  in  1  decoded register writeback.
- Branch  in  1  decoded conditional branch.
- Jump  in  1  decoded JAL/JALR.
- is_jalr  in  1  decoded JALR.
- illegal  in  1  opcode not decodable.
- branch_taken  in  1  comparison result from the ALU/branch unit; valid in WB.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  store access.
- mem_addr_sel  out  1  0 = PC (fetch), 1 = ALU result (data).
- ir_we  out  1  load instruction register.
- mdr_we  out  1  load memory data register.
- reg_we  out  1  register file write.
- pc_we  out  1  PC update.
- pc_src  out  2  00 = PC+4, 01 = PC+imm, 10 = ALU result (JALR).
- state_o  out  3  current state encoding.
- trap  out  1  sticky fault flag.
- trap_cause  out  2  00 = none, 01 = illegal, 10 = memory timeout.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- Reset (async, rst_n low): state = IDLE; every output 0; retired = 0; trap = 0; trap_cause = 00; timer = 0. Asserting reset mid-access drops mem_req in the same instant; no partial write enable may leak out.
- IDLE: all enables 0. Go to FETCH when en = 1.
- FETCH: mem_req = 1, mem_addr_sel = 0, mem_we = 0, held stable until mem_ready is sampled high. In that cycle ir_we = 1 and the next state is DECODE. A zero-wait fetch therefore takes 1 cycle.
- DECODE (1 cycle): if illegal, go to TRAP with cause 01; otherwise go to EXEC.
- EXEC (1 cycle): go to MEM if MemRead or MemWrite; otherwise go to WB.
- MEM: mem_req = 1, mem_addr_sel = 1, mem_we = MemWrite, all held until mem_ready. In the ready cycle, mdr_we = MemRead. Next state is WB.
- WB (1 cycle):
  - reg_we = RegWrite; pc_we = 1; retired increments (wraps at 2**CNT_W).
  - pc_src = 10 if Jump and is_jalr; 01 if Jump, or if Branch and branch_taken; else 00.
  - Next state is FETCH if en = 1, else IDLE. Deasserting en mid-instruction always completes that instruction.
- Timer:
  - Counts consecutive cycles in FETCH or MEM with mem_ready = 0.
  - Clears on mem_ready and on every state change.
  - When it reaches MEM_TIMEOUT (and MEM_TIMEOUT != 0): go to TRAP with cause 10 and drop mem_req next cycle.
  - mem_ready arriving in the same cycle as the timeout wins: the access completes and no trap is raised.
- TRAP: trap = 1, cause held, all enables 0. Sticky until reset; en is ignored.
- mem_ready outside FETCH/MEM is ignored.
- At most one of ir_we, mdr_we, reg_we asserts in any cycle.
- Zero-wait latency: ALU/branch/jump instruction = 4 cycles; load/store = 5 cycles.

Decomposition:
- Shared package core_pkg holds the state encoding (IDLE 000, FETCH 001, DECODE 010, EXEC 011, MEM 100, WB 101, TRAP 110), the pc_src codes and the trap_cause codes.
- One sub-module, mem_wait_timer: TMR_W counter with clear, enable, MEM_TIMEOUT compare, and an expired output.

Test Plan:
- ADD, zero-wait memory, en = 1 → FETCH, DECODE, EXEC, WB in 4 cycles; reg_we = 1 only in WB; pc_src = 00; retired 0 → 1.
- LW with mem_ready held low 2 cycles in MEM → MEM lasts 3 cycles with mem_addr_sel = 1 and mem_we = 0 stable; mdr_we = 1 in the ready cycle; total 7 cycles; reg_we in WB.
- SW, zero-wait → mem_we = 1 in MEM; reg_we = 0 in WB; pc_we = 1; retired increments.
- BEQ with branch_taken = 1, then 0 → pc_src = 01, then 00. JAL → pc_src = 01, reg_we = 1. JALR → pc_src = 10.
- illegal = 1 in DECODE → TRAP, trap_cause = 01, no write enables. Separately, mem_ready stuck low in FETCH → TRAP at 15 cycles with cause 10; mem_ready asserted in the 15th cycle completes with no trap.
- rst_n pulsed low mid-MEM with mem_req = 1 → mem_req = 0 immediately, state_o = 000, retired = 0; restart with en = 1 fetches normally. Separately, en dropped during EXEC → the instruction finishes, then IDLE.
